// File: rtl/wb_dma_arbiter_pkg.sv
// wb_dma_arbiter_pkg: state and grant encodings shared by the arbiter and its users.
package wb_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10,
    ST_ABORT = 2'b11
  } arb_state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/wb_dma_arbiter.sv
// wb_dma_arbiter: two-master pipelined wishbone arbiter (A = CPU, B = DMA).
// Optional bus timeout with ABORT state: define WB_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner; shared bus idle, request fields hold last owner
// ST_OWN_A | master A owns the shared bus
// ST_OWN_B | master B owns the shared bus
// ST_ABORT | timeout fired; bus released, owner stalled until it drops cyc
module wb_dma_arbiter
  import wb_dma_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TMO_LG = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  input  logic          i_stall,
  input  logic          i_err,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_rdata
);

  localparam int CW = TMO_LG + 1;

  arb_state_e    state, state_n;
  logic          last_grant, last_grant_n, gnt_pick;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] stale, stale_n, total;
  logic          owned, own_cyc, own_stb, live, ack_in, route, accept, tmo_hit;

  // The owner (or the last owner, in IDLE) is always the last grant.
  assign owned   = (state == ST_OWN_A) || (state == ST_OWN_B);
  assign own_cyc = (last_grant == GNT_B) ? i_b_cyc : i_a_cyc;
  assign own_stb = (last_grant == GNT_B) ? i_b_stb : i_a_stb;
  assign live    = owned && own_cyc;
  assign ack_in  = i_ack || i_err;
  // Responses still owed to an earlier owner sit ahead of ours and are dropped.
  assign route   = live && (stale == '0);
  assign accept  = live && own_stb && !i_stall;
  assign total   = stale + outstanding;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [TMO_LG-1:0] TMO_LAST = {{(TMO_LG-1){1'b1}}, 1'b0};
  logic [TMO_LG-1:0] tmo_cnt;
  logic              waiting;

  assign waiting = live && (outstanding != '0) && !ack_in;
  assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

  // Timeout counter: cycles spent waiting with no response; fires on the last one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 tmo_cnt <= '0;
    else if (waiting && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    else                          tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State, grant history and response bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= GNT_B;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      outstanding <= outstanding_n;
      stale       <= stale_n;
    end
  end

  // Next state and grant: round-robin on contention, one IDLE cycle between owners.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    gnt_pick     = last_grant;
    case (state)
      ST_IDLE: begin
        if (i_a_cyc && i_b_cyc) gnt_pick = ~last_grant;
        else if (i_b_cyc)       gnt_pick = GNT_B;
        else                    gnt_pick = GNT_A;
        if (i_a_cyc || i_b_cyc) begin
          last_grant_n = gnt_pick;
          state_n      = (gnt_pick == GNT_B) ? ST_OWN_B : ST_OWN_A;
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        if (!own_cyc) state_n = ST_IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo_hit) state_n = ST_ABORT;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!own_cyc) state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Outstanding count for the live owner; anything left when it lets go becomes stale.
  always_comb begin
    outstanding_n = '0;
    stale_n       = stale;
    if (live && !tmo_hit) begin
      outstanding_n = outstanding + CW'(accept)
                      - CW'(route && ack_in && (outstanding != '0));
      stale_n       = stale - CW'(ack_in && (stale != '0));
    end else if (live) begin
      stale_n = total + CW'(accept);
    end else begin
      stale_n = total - CW'(ack_in && (total != '0));
    end
  end

  // Output muxing; reset forces the idle pattern combinationally.
  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = 1'b0;
    o_addr    = '0;
    o_data    = '0;
    o_rdata   = '0;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_a_stall = 1'b1;
    o_b_stall = 1'b1;
    if (i_rst_n) begin
      o_we      = (last_grant == GNT_B) ? i_b_we   : i_a_we;
      o_addr    = (last_grant == GNT_B) ? i_b_addr : i_a_addr;
      o_data    = (last_grant == GNT_B) ? i_b_data : i_a_data;
      o_rdata   = i_data;
      o_a_stall = i_a_stb;
      o_b_stall = i_b_stb;
      case (state)
        ST_OWN_A: begin
          o_cyc     = i_a_cyc;
          o_stb     = i_a_stb;
          o_a_stall = i_stall;
          o_a_ack   = route && i_ack;
          o_a_err   = (route && i_err) || tmo_hit;
        end
        ST_OWN_B: begin
          o_cyc     = i_b_cyc;
          o_stb     = i_b_stb;
          o_b_stall = i_stall;
          o_b_ack   = route && i_ack;
          o_b_err   = (route && i_err) || tmo_hit;
        end
`ifdef WB_ARB_TIMEOUT_EN
        ST_ABORT: begin
          if (last_grant == GNT_B) o_b_stall = 1'b1;
          else                     o_a_stall = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// tb_wb_dma_arbiter: scenario tests plus randomized traffic against a
// transaction-level reference model of the two-master arbiter.
module tb_wb_dma_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO_LG = 4;
`else
  localparam int TMO_LG = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data, o_rdata;
  logic          s_ack, s_stall, s_err;
  logic [DW-1:0] s_data;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model: owner 0 none / 1 A / 2 B, last grant (1 = B), ownership epoch
  int m_owner, m_epoch;
  bit m_last;
  int tag_q[$];
  // slave model: cycle numbers at which responses are due, in order
  int due_q[$];
  int lat_min = 1, lat_max = 3, stall_pct = 0;
  bit err_all = 0, err_some = 0, no_ack = 0;

  bit            exp_cyc, exp_stb, exp_we, exp_a_stall, exp_b_stall;
  bit            exp_a_ack, exp_b_ack, exp_a_err, exp_b_err;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  wb_dma_arbiter #(.AW(AW), .DW(DW), .TMO_LG(TMO_LG)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err), .i_data(s_data),
    .o_rdata(o_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic own(output bit oc, output bit os);
    oc = (m_owner == 1) ? a_cyc : (m_owner == 2) ? b_cyc : 1'b0;
    os = (m_owner == 1) ? a_stb : (m_owner == 2) ? b_stb : 1'b0;
  endtask

  task automatic model_eval();
    bit oc, os, live, mine;
    own(oc, os);
    live        = (m_owner != 0) && oc;
    exp_cyc     = live;
    exp_stb     = (m_owner != 0) && os;
    exp_we      = m_last ? b_we : a_we;
    exp_addr    = m_last ? b_addr : a_addr;
    exp_data    = m_last ? b_data : a_data;
    exp_a_stall = (m_owner == 1) ? s_stall : a_stb;
    exp_b_stall = (m_owner == 2) ? s_stall : b_stb;
    mine        = live && (tag_q.size() == 0 || tag_q[0] == m_epoch);
    exp_a_ack   = (m_owner == 1) && mine && s_ack;
    exp_a_err   = (m_owner == 1) && mine && s_err;
    exp_b_ack   = (m_owner == 2) && mine && s_ack;
    exp_b_err   = (m_owner == 2) && mine && s_err;
  endtask

  task automatic model_advance();
    bit oc, os, live;
    int g, d;
    own(oc, os);
    live = (m_owner != 0) && oc;
    if ((s_ack || s_err) && tag_q.size() > 0) void'(tag_q.pop_front());
    if (live && os && !s_stall) tag_q.push_back(m_epoch);
    if (m_owner != 0) begin
      if (!oc) m_owner = 0;
    end else begin
      g = 0;
      if (a_cyc && b_cyc) g = m_last ? 1 : 2;
      else if (a_cyc)     g = 1;
      else if (b_cyc)     g = 2;
      if (g != 0) begin
        m_owner = g;
        m_last  = (g == 2);
        m_epoch++;
      end
    end
    if ((s_ack || s_err) && due_q.size() > 0) void'(due_q.pop_front());
    if (o_stb && !s_stall && !no_ack) begin
      d = cyc_n + $urandom_range(lat_min, lat_max);
      if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
      due_q.push_back(d);
    end
  endtask

  task automatic drive_slave();
    cyc_n++;
    s_ack = 1'b0;
    s_err = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc_n) begin
      if (err_all || (err_some && $urandom_range(0, 7) == 0)) s_err = 1'b1;
      else s_ack = 1'b1;
    end
    s_stall = ($urandom_range(0, 99) < stall_pct);
    s_data  = $urandom;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic next_cycle();
    model_advance();
    @(posedge clk);
    #1;
    drive_slave();
  endtask

  task automatic masters_idle();
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    masters_idle();
    s_ack = 0; s_err = 0; s_stall = 0;
    due_q.delete();
    tag_q.delete();
    err_all = 0; err_some = 0; no_ack = 0; stall_pct = 0; lat_min = 1; lat_max = 3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_owner = 0; m_last = 1'b1; m_epoch = 0;
    drive_slave();
  endtask

  task automatic test_reset();
    a_cyc = 1; a_stb = 1; a_we = 1; a_addr = $urandom; a_data = $urandom;
    b_cyc = 1; b_stb = 1; b_we = 1; b_addr = $urandom; b_data = $urandom;
    s_ack = 1; s_err = 1; s_stall = 0; s_data = $urandom;
    #12;
    checks++;
    if ({o_cyc, o_stb, o_we} !== 3'b000) begin
      errors++; $display("FAIL reset_req: cyc/stb/we got %b%b%b want 000", o_cyc, o_stb, o_we);
    end
    checks++;
    if (o_addr !== '0 || o_data !== '0 || o_rdata !== '0) begin
      errors++; $display("FAIL reset_bus: addr %0h data %0h rdata %0h want 0", o_addr, o_data, o_rdata);
    end
    checks++;
    if ({o_a_ack, o_a_err, o_b_ack, o_b_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp: ack/err got %b%b%b%b want 0000", o_a_ack, o_a_err, o_b_ack, o_b_err);
    end
    checks++;
    if ({o_a_stall, o_b_stall} !== 2'b11) begin
      errors++; $display("FAIL reset_stall: got %b%b want 11", o_a_stall, o_b_stall);
    end
    do_reset();
  endtask

  task automatic test_a_reads();
    int acc = 0, a_acks = 0, b_acks = 0, n = 0, first_stb = -1;
    do_reset();
    lat_min = 2; lat_max = 2;
    a_cyc = 1; a_stb = 1; a_we = 0;
    while (a_acks < 4 && n < 40) begin
      a_addr = $urandom;
      sample();
      checks++;
      if (o_cyc !== exp_cyc || o_stb !== exp_stb || o_a_stall !== exp_a_stall || o_addr !== exp_addr) begin
        errors++; $display("FAIL a_reads_req: cyc %b stb %b stall %b addr %0h want %b %b %b %0h",
                           o_cyc, o_stb, o_a_stall, o_addr, exp_cyc, exp_stb, exp_a_stall, exp_addr);
      end
      if (o_a_ack) begin
        a_acks++;
        checks++;
        if (o_rdata !== s_data) begin
          errors++; $display("FAIL a_reads_rdata: got %0h want %0h", o_rdata, s_data);
        end
      end
      if (o_b_ack) b_acks++;
      if (o_stb && first_stb < 0) first_stb = n;
      if (o_stb && !o_a_stall) acc++;
      next_cycle();
      n++;
      if (acc >= 4) a_stb = 0;
    end
    checks++;
    if (first_stb !== 1) begin
      errors++; $display("FAIL a_reads_first_stb: cycle %0d want 1", first_stb);
    end
    a_cyc = 0;
    sample();
    checks++;
    if (o_cyc !== 1'b0) begin
      errors++; $display("FAIL a_reads_drop: o_cyc %b want 0", o_cyc);
    end
    next_cycle();
    sample();
    checks++;
    if (o_cyc !== 1'b0 || a_acks != 4 || b_acks != 0) begin
      errors++; $display("FAIL a_reads_count: o_cyc %b a_acks %0d b_acks %0d want 0 4 0", o_cyc, a_acks, b_acks);
    end
    next_cycle();
  endtask

  task automatic test_arbitration();
    bit win_b;
    do_reset();
    no_ack = 1;
    for (int r = 0; r < 3; r++) begin
      win_b = (r == 1);
      a_cyc = 1; b_cyc = 1; a_stb = 1; b_stb = 1;
      a_addr = $urandom; b_addr = $urandom;
      sample();
      checks++;
      if (o_cyc !== 1'b0) begin
        errors++; $display("FAIL arb_early r%0d: o_cyc %b want 0", r, o_cyc);
      end
      next_cycle();
      sample();
      checks++;
      if (o_cyc !== 1'b1 || o_addr !== (win_b ? b_addr : a_addr)) begin
        errors++; $display("FAIL arb_grant r%0d: o_cyc %b addr %0h want 1 %0h", r, o_cyc, o_addr,
                           win_b ? b_addr : a_addr);
      end
      checks++;
      if ((win_b ? o_a_stall : o_b_stall) !== 1'b1) begin
        errors++; $display("FAIL arb_loser_stall r%0d: got 0 want 1", r);
      end
      next_cycle();
      masters_idle();
      sample();
      next_cycle();
      sample();
      next_cycle();
    end
  endtask

  task automatic test_b_writes();
    int bacc = 0, backs = 0, n = 0;
    do_reset();
    stall_pct = 25;
    b_cyc = 1; b_stb = 1; b_we = 1;
    sample();
    next_cycle();
    a_cyc = 1; a_stb = 1;
    while (backs < 8 && n < 100) begin
      b_addr = $urandom; b_data = $urandom; a_addr = $urandom;
      sample();
      checks++;
      if (o_a_stall !== 1'b1 || o_a_ack !== 1'b0) begin
        errors++; $display("FAIL b_writes_a_blocked: stall %b ack %b want 1 0", o_a_stall, o_a_ack);
      end
      if (o_stb) begin
        checks++;
        if (o_we !== 1'b1 || o_addr !== b_addr || o_data !== b_data) begin
          errors++; $display("FAIL b_writes_bus: we %b addr %0h data %0h want 1 %0h %0h",
                             o_we, o_addr, o_data, b_addr, b_data);
        end
      end
      if (o_stb && !o_b_stall) bacc++;
      if (o_b_ack) backs++;
      next_cycle();
      n++;
      if (bacc >= 8) b_stb = 0;
    end
    checks++;
    if (bacc != 8 || backs != 8) begin
      errors++; $display("FAIL b_writes_count: accepted %0d acks %0d want 8 8", bacc, backs);
    end
    b_cyc = 0; b_we = 0;
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++;
      if (o_cyc !== 1'b0 || o_a_stall !== 1'b1) begin
        errors++; $display("FAIL b_handover_gap k%0d: o_cyc %b a_stall %b want 0 1", k, o_cyc, o_a_stall);
      end
      next_cycle();
    end
    sample();
    checks++;
    if (o_cyc !== 1'b1 || o_addr !== a_addr || o_a_stall !== s_stall) begin
      errors++; $display("FAIL b_handover_a: o_cyc %b addr %0h stall %b want 1 %0h %b",
                         o_cyc, o_addr, o_a_stall, a_addr, s_stall);
    end
    next_cycle();
  endtask

  task automatic test_err();
    int errs = 0, n = 0;
    do_reset();
    err_all = 1; lat_min = 1; lat_max = 2;
    b_cyc = 1; b_stb = 1; b_we = 0;
    while (n < 20) begin
      sample();
      checks++;
      if (o_a_err !== 1'b0 || o_b_ack !== 1'b0) begin
        errors++; $display("FAIL err_route: a_err %b b_ack %b want 0 0", o_a_err, o_b_ack);
      end
      if (o_b_err) errs++;
      if (o_stb && !o_b_stall) begin
        next_cycle();
        b_stb = 0;
      end else begin
        next_cycle();
      end
      n++;
    end
    checks++;
    if (errs != 1) begin
      errors++; $display("FAIL err_pulse: o_b_err cycles %0d want 1", errs);
    end
    masters_idle();
  endtask

  task automatic test_random();
    do_reset();
    stall_pct = 30; err_some = 1; lat_min = 1; lat_max = 3;
    for (int n = 0; n < 1500; n++) begin
      if (!a_cyc) a_cyc = ($urandom_range(0, 5) == 0);
      else if ($urandom_range(0, 9) == 0) a_cyc = 0;
      if (!b_cyc) b_cyc = ($urandom_range(0, 5) == 0);
      else if ($urandom_range(0, 9) == 0) b_cyc = 0;
      a_stb = a_cyc && ($urandom_range(0, 1) == 1);
      b_stb = b_cyc && ($urandom_range(0, 1) == 1);
      a_we = $urandom_range(0, 1); b_we = $urandom_range(0, 1);
      a_addr = $urandom; b_addr = $urandom; a_data = $urandom; b_data = $urandom;
      sample();
      checks++;
      if (o_cyc !== exp_cyc || o_stb !== exp_stb) begin
        errors++; $display("FAIL rnd_req n%0d: cyc %b stb %b want %b %b", n, o_cyc, o_stb, exp_cyc, exp_stb);
      end
      checks++;
      if (o_we !== exp_we || o_addr !== exp_addr || o_data !== exp_data) begin
        errors++; $display("FAIL rnd_mux n%0d: we %b addr %0h data %0h want %b %0h %0h",
                           n, o_we, o_addr, o_data, exp_we, exp_addr, exp_data);
      end
      checks++;
      if (o_a_stall !== exp_a_stall || o_b_stall !== exp_b_stall) begin
        errors++; $display("FAIL rnd_stall n%0d: a %b b %b want %b %b", n, o_a_stall, o_b_stall,
                           exp_a_stall, exp_b_stall);
      end
      checks++;
      if ({o_a_ack, o_a_err, o_b_ack, o_b_err} !== {exp_a_ack, exp_a_err, exp_b_ack, exp_b_err}) begin
        errors++; $display("FAIL rnd_resp n%0d: a ack/err %b%b b ack/err %b%b want %b%b %b%b", n,
                           o_a_ack, o_a_err, o_b_ack, o_b_err, exp_a_ack, exp_a_err, exp_b_ack, exp_b_err);
      end
      checks++;
      if (o_rdata !== s_data) begin
        errors++; $display("FAIL rnd_rdata n%0d: got %0h want %0h", n, o_rdata, s_data);
      end
      next_cycle();
    end
    masters_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    no_ack = 1;
    a_cyc = 1; a_stb = 1; a_addr = $urandom;
    repeat (4) begin
      sample();
      next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_cyc !== 1'b0 || o_stb !== 1'b0 || o_a_stall !== 1'b1) begin
      errors++; $display("FAIL reset_mid_drop: cyc %b stb %b a_stall %b want 0 0 1", o_cyc, o_stb, o_a_stall);
    end
    do_reset();
    a_cyc = 1; b_cyc = 1; a_addr = $urandom; b_addr = $urandom;
    sample();
    next_cycle();
    sample();
    checks++;
    if (o_cyc !== 1'b1 || o_addr !== a_addr) begin
      errors++; $display("FAIL reset_mid_regrant: cyc %b addr %0h want 1 %0h", o_cyc, o_addr, a_addr);
    end
    next_cycle();
    masters_idle();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int first = 0;
    do_reset();
    no_ack = 1;
    a_cyc = 1; a_stb = 1;
    sample();
    next_cycle();
    sample();
    checks++;
    if (o_stb !== 1'b1 || o_a_stall !== 1'b0) begin
      errors++; $display("FAIL tmo_strobe: stb %b stall %b want 1 0", o_stb, o_a_stall);
    end
    next_cycle();
    a_stb = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      sample();
      if (o_a_err) first = k;
      next_cycle();
    end
    checks++;
    if (first != 15) begin
      errors++; $display("FAIL tmo_delay: err after %0d cycles want 15", first);
    end
    repeat (3) begin
      sample();
      checks++;
      if (o_cyc !== 1'b0 || o_a_stall !== 1'b1 || o_a_err !== 1'b0) begin
        errors++; $display("FAIL tmo_abort: cyc %b stall %b err %b want 0 1 0", o_cyc, o_a_stall, o_a_err);
      end
      next_cycle();
    end
    a_cyc = 0;
    sample();
    next_cycle();
    a_stb = 0;
    sample();
    checks++;
    if (o_a_stall !== 1'b0 || o_cyc !== 1'b0) begin
      errors++; $display("FAIL tmo_release: stall %b cyc %b want 0 0", o_a_stall, o_cyc);
    end
    next_cycle();
  endtask
`endif

  initial begin
    masters_idle();
    s_ack = 0; s_err = 0; s_stall = 0; s_data = '0;
    test_reset();
    test_a_reads();
    test_arbitration();
    test_b_writes();
    test_err();
    test_random();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
